// File: rtl/opll_bus_pkg.sv
// Shared types and constants for the OPLL host-side register write sequencer.
// Timing defaults are the OPLL post-write busy times in master clocks.
package opll_bus_pkg;

   localparam int unsigned BUS_DW = 8;
   localparam int unsigned BUS_AW = 8;
   localparam int unsigned REQ_W  = BUS_AW + BUS_DW;

   localparam int unsigned OPLL_ADDR_WAIT = 12;
   localparam int unsigned OPLL_DATA_WAIT = 84;

   typedef enum logic [2:0] {
      StIdle,
      StASetup,
      StAStrobe,
      StAWait,
      StDSetup,
      StDStrobe,
      StDWait
   } wr_state_e;

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // Counter load for an N-cycle phase; a zero-length phase still takes one cycle.
   function automatic int unsigned cyc_load(input int unsigned n);
      return (n == 0) ? 0 : n - 1;
   endfunction

endpackage

// File: rtl/opll_bus_writer_if.sv
// Host request stream plus the OPLL 8-bit write bus (CS/WR active high here).
interface opll_bus_writer_if;
   import opll_bus_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [BUS_AW-1:0] in_addr;
   logic [BUS_DW-1:0] in_data;
   logic [BUS_DW-1:0] bus_d;
   logic              bus_a0;
   logic              bus_cs;
   logic              bus_wr;

   modport master (
      output in_valid, in_addr, in_data,
      input  in_ready, bus_d, bus_a0, bus_cs, bus_wr
   );

   modport slave (
      input  in_valid, in_addr, in_data,
      output in_ready, bus_d, bus_a0, bus_cs, bus_wr
   );

endinterface

// File: rtl/opll_wr_fifo.sv
// Write-request FIFO; pointers carry an extra wrap bit to tell full from empty.
module opll_wr_fifo
   import opll_bus_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = REQ_W
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wdata,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rdata,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // A push is refused when full even if a pop happens in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem_q[rptr_q[AW-1:0]];
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign level = LW'(wptr_q - rptr_q);

endmodule

// File: rtl/opll_bus_writer.sv
// Replays buffered (address, data) pairs onto the OPLL bus as an address write
// followed by a data write, honouring setup, strobe and post-write wait times.
module opll_bus_writer
   import opll_bus_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned SETUP_CYC      = 1,
   parameter int unsigned STROBE_CYC     = 4,
   parameter int unsigned ADDR_WAIT_CYC  = OPLL_ADDR_WAIT,
   parameter int unsigned DATA_WAIT_CYC  = OPLL_DATA_WAIT,
   parameter int unsigned SKIP_SAME_ADDR = 0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   opll_bus_writer_if.slave                  bus,
   output logic                              busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              done
);

   localparam int unsigned MaxCyc = max4(SETUP_CYC, STROBE_CYC, ADDR_WAIT_CYC, DATA_WAIT_CYC);
   localparam int unsigned CntW   = $clog2(MaxCyc + 1);

   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t SetupLd    = cnt_t'(cyc_load(SETUP_CYC));
   localparam cnt_t StrobeLd   = cnt_t'(cyc_load(STROBE_CYC));
   localparam cnt_t AddrWaitLd = cnt_t'(cyc_load(ADDR_WAIT_CYC));
   localparam cnt_t DataWaitLd = cnt_t'(cyc_load(DATA_WAIT_CYC));

   wr_state_e         state_q, state_d;
   cnt_t              cnt_q, cnt_d;
   logic [BUS_AW-1:0] addr_q, addr_d;
   logic [BUS_DW-1:0] data_q, data_d;
   logic [BUS_DW-1:0] bus_d_q, bus_d_d;
   logic              bus_a0_q, bus_a0_d;
   logic [BUS_AW-1:0] last_addr_q, last_addr_d;
   logic              cache_v_q, cache_v_d;

   logic              fifo_pop, fifo_full, fifo_empty;
   logic [REQ_W-1:0]  fifo_rdata;
   logic [BUS_AW-1:0] rd_addr;
   logic [BUS_DW-1:0] rd_data;
   logic              cnt_zero, addr_hit, strobe;

   opll_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REQ_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (bus.in_valid),
      .wdata ({bus.in_addr, bus.in_data}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   assign rd_addr  = fifo_rdata[REQ_W-1 -: BUS_AW];
   assign rd_data  = fifo_rdata[BUS_DW-1:0];
   assign cnt_zero = (cnt_q == '0);
   assign addr_hit = (SKIP_SAME_ADDR != 0) && cache_v_q && (rd_addr == last_addr_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         bus_d_q     <= '0;
         bus_a0_q    <= 1'b0;
         last_addr_q <= '0;
         cache_v_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         bus_d_q     <= bus_d_d;
         bus_a0_q    <= bus_a0_d;
         last_addr_q <= last_addr_d;
         cache_v_q   <= cache_v_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_zero ? cnt_q : cnt_q - cnt_t'(1);
      addr_d      = addr_q;
      data_d      = data_q;
      bus_d_d     = bus_d_q;
      bus_a0_d    = bus_a0_q;
      last_addr_d = last_addr_q;
      cache_v_d   = cache_v_q;
      fifo_pop    = 1'b0;
      done        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               addr_d   = rd_addr;
               data_d   = rd_data;
               cnt_d    = SetupLd;
               if (addr_hit) begin
                  state_d  = StDSetup;
                  bus_d_d  = rd_data;
                  bus_a0_d = 1'b1;
               end else begin
                  state_d  = StASetup;
                  bus_d_d  = rd_addr;
                  bus_a0_d = 1'b0;
               end
            end
         end
         StASetup: begin
            if (cnt_zero) begin
               state_d = StAStrobe;
               cnt_d   = StrobeLd;
            end
         end
         StAStrobe: begin
            last_addr_d = addr_q;
            cache_v_d   = 1'b1;
            if (cnt_zero) begin
               state_d = StAWait;
               cnt_d   = AddrWaitLd;
            end
         end
         StAWait: begin
            if (cnt_zero) begin
               state_d  = StDSetup;
               cnt_d    = SetupLd;
               bus_d_d  = data_q;
               bus_a0_d = 1'b1;
            end
         end
         StDSetup: begin
            if (cnt_zero) begin
               state_d = StDStrobe;
               cnt_d   = StrobeLd;
            end
         end
         StDStrobe: begin
            if (cnt_zero) begin
               state_d = StDWait;
               cnt_d   = DataWaitLd;
            end
         end
         StDWait: begin
            if (cnt_zero) begin
               done    = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // CS and WR come straight from the state register so reset drops them at once.
   assign strobe       = (state_q == StAStrobe) || (state_q == StDStrobe);
   assign bus.bus_cs   = strobe;
   assign bus.bus_wr   = strobe;
   assign bus.bus_d    = bus_d_q;
   assign bus.bus_a0   = bus_a0_q;
   assign bus.in_ready = !fifo_full;
   assign busy         = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_opll_bus_writer.sv
// Randomized scoreboard bench: two writers (address skip off/on) share stimulus
// order; a cycle-level schedule model predicts every strobe, done pulse and level.
module tb_opll_bus_writer;
   import opll_bus_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam int unsigned LW       = $clog2(DEPTH + 1);
   localparam longint      T_SETUP  = 1;
   localparam longint      T_STROBE = 4;
   localparam longint      T_AWAIT  = 12;
   localparam longint      T_DWAIT  = 84;

   typedef struct { logic [7:0] addr; logic [7:0] data; int gap; } req_t;
   typedef struct { longint pop; longint done; } sched_t;
   typedef struct { longint start; logic a0; logic [7:0] d; } strobe_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   longint cyc = 0;
   int     checks = 0;
   int     errors = 0;
   req_t   stim[$];
   int     issue_upto = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   function automatic void timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      opll_bus_writer_if bus_if ();
      logic            busy, done;
      logic [LW-1:0]   fifo_level;
      int              issued = 0;
      sched_t          sched[$];
      strobe_t         strobes[$];
      longint          done_q[$];
      longint          last_done = -1;
      logic            cache_v = 1'b0;
      logic [7:0]      cache_a = 8'h00;

      opll_bus_writer #(
         .FIFO_DEPTH     (DEPTH),
         .SKIP_SAME_ADDR (g)
      ) dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .bus        (bus_if),
         .busy       (busy),
         .fifo_level (fifo_level),
         .done       (done)
      );

      initial begin : drv
         int t;
         bus_if.in_valid = 1'b0;
         bus_if.in_addr  = 8'h00;
         bus_if.in_data  = 8'h00;
         forever begin
            if (rst_n && issued < issue_upto) begin
               for (int i = 0; i < stim[issued].gap; i++) begin
                  @(posedge clk); #1;
               end
               bus_if.in_valid = 1'b1;
               bus_if.in_addr  = stim[issued].addr;
               bus_if.in_data  = stim[issued].data;
               t = 0;
               @(negedge clk);
               while (!bus_if.in_ready && t < 2000) begin
                  @(negedge clk);
                  t++;
               end
               if (t >= 2000) timeout($sformatf("u%0d in_ready", g));
               @(posedge clk); #1;
               bus_if.in_valid = 1'b0;
               issued++;
            end else begin
               @(posedge clk); #1;
            end
         end
      end

      always @(negedge clk) begin : mon
         string   u;
         longint  k, pop_c, a_start, d_start, done_c;
         int      lvl;
         logic    cs_exp, done_exp, skip;
         u = $sformatf("u%0d", g);
         if (!rst_n) begin
            sched.delete();
            strobes.delete();
            done_q.delete();
            last_done = -1;
            cache_v   = 1'b0;
         end else begin
            k = cyc;
            while (sched.size() > 0 && sched[0].done < k) void'(sched.pop_front());
            lvl = 0;
            foreach (sched[i]) if (sched[i].pop >= k) lvl++;
            chk({u, " fifo_level"}, fifo_level, lvl);
            chk({u, " in_ready"}, bus_if.in_ready, (lvl < DEPTH));
            chk({u, " busy"}, busy, (sched.size() > 0));

            while (strobes.size() > 0 && strobes[0].start + T_STROBE <= k)
               void'(strobes.pop_front());
            cs_exp = (strobes.size() > 0) && (strobes[0].start <= k);
            chk({u, " bus_cs"}, bus_if.bus_cs, cs_exp);
            chk({u, " bus_wr"}, bus_if.bus_wr, cs_exp);
            if (strobes.size() > 0 && strobes[0].start - T_SETUP <= k) begin
               chk({u, " bus_d"}, bus_if.bus_d, strobes[0].d);
               chk({u, " bus_a0"}, bus_if.bus_a0, strobes[0].a0);
            end

            done_exp = (done_q.size() > 0) && (done_q[0] == k);
            chk({u, " done"}, done, done_exp);
            while (done_q.size() > 0 && done_q[0] <= k) void'(done_q.pop_front());

            // Accepted this cycle: schedule it after whatever is already queued.
            if (bus_if.in_valid && lvl < DEPTH) begin
               pop_c = (k + 1 > last_done + 1) ? k + 1 : last_done + 1;
               skip  = (g != 0) && cache_v && (cache_a == bus_if.in_addr);
               if (skip) begin
                  d_start = pop_c + 1 + T_SETUP;
               end else begin
                  a_start = pop_c + 1 + T_SETUP;
                  strobes.push_back('{a_start, 1'b0, bus_if.in_addr});
                  d_start = a_start + T_STROBE + T_AWAIT + T_SETUP;
               end
               strobes.push_back('{d_start, 1'b1, bus_if.in_data});
               done_c = d_start + T_STROBE + T_DWAIT - 1;
               done_q.push_back(done_c);
               sched.push_back('{pop_c, done_c});
               last_done = done_c;
               cache_v   = 1'b1;
               cache_a   = bus_if.in_addr;
            end
         end
      end
   end

   task automatic check_reset(input string u, input logic rdy, input logic cs, input logic wr,
                              input logic [7:0] d, input logic a0, input logic bsy,
                              input logic dn, input logic [LW-1:0] lvl);
      chk({u, " rst in_ready"}, rdy, 1);
      chk({u, " rst bus_cs"}, cs, 0);
      chk({u, " rst bus_wr"}, wr, 0);
      chk({u, " rst bus_d"}, d, 0);
      chk({u, " rst bus_a0"}, a0, 0);
      chk({u, " rst busy"}, bsy, 0);
      chk({u, " rst done"}, dn, 0);
      chk({u, " rst fifo_level"}, lvl, 0);
   endtask

   task automatic check_both_reset();
      check_reset("u0", g_dut[0].bus_if.in_ready, g_dut[0].bus_if.bus_cs,
                  g_dut[0].bus_if.bus_wr, g_dut[0].bus_if.bus_d, g_dut[0].bus_if.bus_a0,
                  g_dut[0].busy, g_dut[0].done, g_dut[0].fifo_level);
      check_reset("u1", g_dut[1].bus_if.in_ready, g_dut[1].bus_if.bus_cs,
                  g_dut[1].bus_if.bus_wr, g_dut[1].bus_if.bus_d, g_dut[1].bus_if.bus_a0,
                  g_dut[1].busy, g_dut[1].done, g_dut[1].fifo_level);
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] d, input int gap);
      stim.push_back('{a, d, gap});
      issue_upto = stim.size();
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while (!(g_dut[0].issued == issue_upto && g_dut[1].issued == issue_upto &&
               !g_dut[0].busy && !g_dut[1].busy) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 5000) timeout(name);
      repeat (3) @(negedge clk);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : seq
      int          t;
      logic [7:0]  a;
      repeat (2) @(negedge clk);
      check_both_reset();
      @(posedge clk); #3;
      rst_n = 1'b1;

      issue(8'h10, 8'h5A, 0);
      wait_idle("single");

      for (int i = 0; i < 6; i++) issue(8'h40 + 8'(i), 8'($urandom), 0);
      wait_idle("burst");

      issue(8'h20, 8'h01, 0);
      issue(8'h20, 8'h02, 0);
      wait_idle("same_addr");

      for (int i = 0; i < 10; i++) begin
         a = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h20 + 8'($urandom_range(0, 1));
         issue(a, 8'($urandom), ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 150)));
      end
      wait_idle("random");

      // Reset in the middle of the data strobe.
      issue(8'h33, 8'h44, 0);
      t = 0;
      @(negedge clk);
      while (!(g_dut[0].bus_if.bus_cs && g_dut[0].bus_if.bus_a0) && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) timeout("reach data strobe");
      @(posedge clk); #2;
      chk("u0 cs before reset", g_dut[0].bus_if.bus_cs, 1);
      rst_n = 1'b0;
      #1;
      check_both_reset();
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;

      issue(8'h33, 8'h55, 2);
      issue(8'h33, 8'h66, 0);
      wait_idle("after reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
